vfadd_pipe: RTL and testbench

VFADD_PIPE -- requirements
Module: vfadd_pipe

---
 rtl/vfadd_pipe.sv | 165 ++++++++++++++++
 tb/tb_vfadd_pipe.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vfadd_pipe.sv
// vfadd_pipe: LANES-wide FP16 (1-5-10) add/subtract, three-stage valid/ready pipeline.
// Optional macro VFADD_SAT_EN: overflowing lanes saturate to max finite instead of infinity.
module vfadd_pipe #(
  parameter int LANES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  op,
  input  logic [16*LANES-1:0]   op_1,
  input  logic [16*LANES-1:0]   op_2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*LANES-1:0]   sum,
  output logic [LANES-1:0]      ovf
);

`ifdef VFADD_SAT_EN
  localparam logic [14:0] OVF_MAG = 15'h7BFF;
`else
  localparam logic [14:0] OVF_MAG = 15'h7C00;
`endif

  // S1 result: operands swapped so ma is the larger magnitude, mb already aligned.
  typedef struct packed {
    logic        sign;
    logic        sub;
    logic        nan;
    logic [4:0]  exp;
    logic [10:0] ma;
    logic [10:0] mb;
  } s1_t;

  typedef struct packed {
    logic        sign;
    logic        nan;
    logic [4:0]  exp;
    logic [12:0] mag;
  } s2_t;

  function automatic s1_t unpack_align(input logic [15:0] a, input logic [15:0] b,
                                       input logic sub);
    s1_t        r;
    logic       sb;
    logic [4:0] ea, eb, diff;
    logic [10:0] ma, mb;
    sb = b[15] ^ sub;
    ea = a[14:10];
    eb = b[14:10];
    ma = (ea == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
    mb = (eb == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
    r.nan = (ea == 5'd31) || (eb == 5'd31);
    r.sub = a[15] ^ sb;
    if ({eb, mb} > {ea, ma}) begin
      r.sign = sb;
      r.exp  = eb;
      r.ma   = mb;
      diff   = eb - ea;
      r.mb   = (diff >= 5'd13) ? 11'd0 : (ma >> diff);
    end else begin
      r.sign = a[15];
      r.exp  = ea;
      r.ma   = ma;
      diff   = ea - eb;
      r.mb   = (diff >= 5'd13) ? 11'd0 : (mb >> diff);
    end
    return r;
  endfunction

  // Larger magnitude is always in ma, so the difference never goes negative.
  function automatic s2_t add_mag(input s1_t s);
    s2_t r;
    r.sign = s.sign;
    r.nan  = s.nan;
    r.exp  = s.exp;
    r.mag  = s.sub ? ({2'b00, s.ma} - {2'b00, s.mb}) : ({2'b00, s.ma} + {2'b00, s.mb});
    return r;
  endfunction

  // Returns {ovf, packed FP16}.
  function automatic logic [16:0] pack_lane(input s2_t s);
    logic [16:0] r;
    logic [9:0]  m;
    logic        found;
    int          e;
    int          lz;
    r     = '0;
    m     = '0;
    found = 1'b0;
    e     = 0;
    lz    = 0;
    if (s.nan) begin
      r = {1'b0, 16'h7E00};
    end else if (s.mag != 13'd0) begin
      if (s.mag[11]) begin
        m = s.mag[10:1];
        e = int'(s.exp) + 1;
      end else begin
        for (int i = 10; i >= 0; i--) begin
          if (!found) begin
            if (s.mag[i]) found = 1'b1;
            else lz++;
          end
        end
        m = s.mag[9:0] << lz;
        e = int'(s.exp) - lz;
      end
      if (e < 1)       r = {1'b0, s.sign, 15'd0};
      else if (e > 30) r = {1'b1, s.sign, OVF_MAG};
      else             r = {1'b0, s.sign, e[4:0], m};
    end
    return r;
  endfunction

  // Handshake: a beat moves when valid and ready are both high in the same cycle.
  // All three stages shift together whenever the output register is empty or draining.
  logic advance;
  logic v1, v2;
  s1_t  s1_d [LANES];
  s1_t  s1_q [LANES];
  s2_t  s2_d [LANES];
  s2_t  s2_q [LANES];
  logic [16*LANES-1:0] sum_d;
  logic [LANES-1:0]    ovf_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign s1_d[i] = unpack_align(op_1[16*i +: 16], op_2[16*i +: 16], op);
    assign s2_d[i] = add_mag(s1_q[i]);
    assign {ovf_d[i], sum_d[16*i +: 16]} = pack_lane(s2_q[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      out_valid <= 1'b0;
    end else if (advance) begin
      v1        <= in_valid;
      v2        <= v1;
      out_valid <= v2;
    end
  end

  always_ff @(posedge clk) begin
    if (advance) begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
      ovf <= '0;
    end else if (advance) begin
      sum <= sum_d;
      ovf <= ovf_d;
    end
  end

endmodule

// File: tb/tb_vfadd_pipe.sv
// tb_vfadd_pipe: directed and randomized checks of vfadd_pipe against an integer-arithmetic FP16 model.
// Honours VFADD_SAT_EN the same way as the design.
module tb_vfadd_pipe;
  localparam int LANES = 16;
  localparam int VW    = 16 * LANES;
  localparam int RW    = 17 * LANES;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          op;
  logic [VW-1:0] op_1, op_2;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] sum;
  logic [LANES-1:0] ovf;

  int n_cmp = 0;
  int n_bad = 0;
  logic [RW-1:0] exp_q[$];
  logic          bp_mode = 1'b0;
  logic          prev_stall = 1'b0;
  logic [RW:0]   prev_out;
  logic [RW-1:0] mon_exp;

  vfadd_pipe #(.LANES(LANES)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .op_1(op_1), .op_2(op_2), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .ovf(ovf)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Value-level model: both operands expressed as integers in units of the
  // larger exponent's ulp, summed, then re-encoded with truncation.
  function automatic logic [16:0] model_lane(input logic [15:0] a, input logic [15:0] b,
                                             input logic sub);
    int ea, eb, e, va, vb, s, m, p, re, mant;
    logic neg;
    logic sb;
    sb = b[15] ^ sub;
    ea = int'(a[14:10]);
    eb = int'(b[14:10]);
    if (ea == 31 || eb == 31) return 17'h07E00;
    va = (ea == 0) ? 0 : 1024 + int'(a[9:0]);
    vb = (eb == 0) ? 0 : 1024 + int'(b[9:0]);
    e  = (ea > eb) ? ea : eb;
    va = va >> (e - ea);
    vb = vb >> (e - eb);
    if (a[15]) va = -va;
    if (sb)    vb = -vb;
    s = va + vb;
    if (s == 0) return 17'h00000;
    neg = (s < 0);
    m   = neg ? -s : s;
    p   = 0;
    while ((m >> (p + 1)) != 0) p++;
    re = e + p - 10;
    if (re < 1) return {1'b0, neg, 15'd0};
`ifdef VFADD_SAT_EN
    if (re > 30) return {1'b1, neg, 15'h7BFF};
`else
    if (re > 30) return {1'b1, neg, 15'h7C00};
`endif
    mant = (p >= 10) ? (m >> (p - 10)) : (m << (10 - p));
    return {1'b0, neg, re[4:0], mant[9:0]};
  endfunction

  function automatic logic [RW-1:0] model_vec(input logic [VW-1:0] a, input logic [VW-1:0] b,
                                              input logic sub);
    logic [VW-1:0]    s;
    logic [LANES-1:0] o;
    logic [16:0]      r;
    for (int i = 0; i < LANES; i++) begin
      r = model_lane(a[16*i +: 16], b[16*i +: 16], sub);
      o[i] = r[16];
      s[16*i +: 16] = r[15:0];
    end
    return {o, s};
  endfunction

  function automatic logic [VW-1:0] bcast(input logic [15:0] v);
    return {LANES{v}};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [RW-1:0] act, input logic [RW-1:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", RW'(prev_out), RW'({out_valid, ovf, sum}));
      check("in_ready", RW'(in_ready), RW'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %h with nothing outstanding", {ovf, sum});
        end else begin
          mon_exp = exp_q.pop_front();
          check("result", {ovf, sum}, mon_exp);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model_vec(op_1, op_2, op));
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, ovf, sum};
    end
  end

  always @(posedge clk) begin
    if (bp_mode) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [VW-1:0] a, input logic [VW-1:0] b, input logic o);
    logic acc;
    int   guard;
    acc   = 1'b0;
    guard = 0;
    op_1 = a;
    op_2 = b;
    op   = o;
    in_valid = 1'b1;
    while (!acc && guard < 1000) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready=0 for %0d cycles want 1", guard);
    end
  endtask

  task automatic timed(input string name, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic o, input logic [RW-1:0] want);
    int n;
    send(a, b, o);
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, RW'(n), RW'(3));
    check(name, {ovf, sum}, want);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 500) begin
      @(posedge clk);
      g++;
    end
    #1;
    if (g >= 500) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d outstanding want 0", exp_q.size());
    end
  endtask

  function automatic logic [15:0] rand_half(input int near);
    int r, e;
    r = $urandom_range(0, 15);
    if (r == 0)      e = 0;
    else if (r == 1) e = 31;
    else if (r == 2) e = 30;
    else begin
      e = near + $urandom_range(0, 24) - 12;
      if (e < 1)  e = 1;
      if (e > 30) e = 30;
    end
    return {1'($urandom_range(0, 1)), e[4:0], 10'($urandom_range(0, 1023))};
  endfunction

  task automatic gen(output logic [VW-1:0] a, output logic [VW-1:0] b);
    logic [15:0] x;
    for (int i = 0; i < LANES; i++) begin
      x = rand_half($urandom_range(1, 30));
      a[16*i +: 16] = x;
      b[16*i +: 16] = ($urandom_range(0, 1) == 1) ? rand_half(int'(x[14:10]))
                                                    : rand_half($urandom_range(1, 30));
    end
  endtask

  // ---------------- main sequence ----------------
  logic [VW-1:0] va, vb, wsum;
  logic [15:0]   ovf_word;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    op = 1'b0;
    op_1 = '0;
    op_2 = '0;
    out_ready = 1'b1;
    #3;
    check("reset_out_valid", RW'(out_valid), RW'(0));
    check("reset_in_ready",  RW'(in_ready),  RW'(1));
    check("reset_sum_ovf",   {ovf, sum},     '0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // hand-computed anchors for the model itself
    check("model_1p1",   RW'(model_lane(16'h3C00, 16'h3C00, 1'b0)), RW'(17'h04000));
    check("model_1m1",   RW'(model_lane(16'h3C00, 16'h3C00, 1'b1)), RW'(17'h00000));
    check("model_2m1",   RW'(model_lane(16'h4000, 16'h3C00, 1'b1)), RW'(17'h03C00));
    check("model_trunc", RW'(model_lane(16'h3C00, 16'h1000, 1'b0)), RW'(17'h03C00));
    check("model_inf",   RW'(model_lane(16'h7C00, 16'h3C00, 1'b0)), RW'(17'h07E00));
    check("model_uflow", RW'(model_lane(16'h0400, 16'h0401, 1'b1)), RW'(17'h08000));
`ifdef VFADD_SAT_EN
    check("model_ovf",   RW'(model_lane(16'h7BFF, 16'h7BFF, 1'b0)), RW'(17'h17BFF));
`else
    check("model_ovf",   RW'(model_lane(16'h7BFF, 16'h7BFF, 1'b0)), RW'(17'h17C00));
`endif

    // directed vectors through the DUT
    timed("add_one_one", bcast(16'h3C00), bcast(16'h3C00), 1'b0, {16'h0000, bcast(16'h4000)});
    va = bcast(16'h3C00);
    va[31:16] = 16'h4000;
    wsum = '0;
    wsum[31:16] = 16'h3C00;
    timed("sub_lanes", va, bcast(16'h3C00), 1'b1, {16'h0000, wsum});
`ifdef VFADD_SAT_EN
    timed("add_ovf", bcast(16'h7BFF), bcast(16'h7BFF), 1'b0, {16'hFFFF, bcast(16'h7BFF)});
`else
    timed("add_ovf", bcast(16'h7BFF), bcast(16'h7BFF), 1'b0, {16'hFFFF, bcast(16'h7C00)});
`endif
    timed("add_trunc", bcast(16'h3C00), bcast(16'h1000), 1'b0, {16'h0000, bcast(16'h3C00)});
    timed("add_inf", bcast(16'h7C00), bcast(16'h3C00), 1'b0, {16'h0000, bcast(16'h7E00)});
    ovf_word = 16'h0000;
    timed("sub_neg", bcast(16'h3C00), bcast(16'h4000), 1'b1, {ovf_word, bcast(16'hBC00)});

    // stream 8 vectors with a 5-cycle output stall in the middle
    fork
      begin
        logic [VW-1:0] a, b;
        for (int k = 0; k < 8; k++) begin
          gen(a, b);
          send(a, b, 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("stall_in_ready", RW'({out_valid, in_ready}), RW'(2'b10));
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();

    // reset with three vectors in flight
    for (int k = 0; k < 3; k++) begin
      gen(va, vb);
      send(va, vb, 1'b0);
    end
    #2 rst = 1'b1;
    #1;
    check("midreset_out_valid", RW'({out_valid, in_ready}), RW'(2'b01));
    check("midreset_sum_ovf", {ovf, sum}, '0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("post_reset_idle", RW'(out_valid), RW'(0));
    timed("post_reset_fresh", bcast(16'h3C00), bcast(16'h3C00), 1'b0, {16'h0000, bcast(16'h4000)});

    // randomized traffic with random backpressure
    bp_mode = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      gen(va, vb);
      send(va, vb, 1'($urandom_range(0, 1)));
    end
    bp_mode = 1'b0;
    @(posedge clk);
    #2 out_ready = 1'b1;
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
